// File: rtl/dma_master_engine_if.sv
// -----------------------------------------------------------------------------
// dma_master_engine_if
// AXI master-port bundle used by dma_master_engine.
//   AR channel : M_ARID/Addr/Len/Size/Burst/Valid (master out), M_ARReady (in)
//   R  channel : M_RID/RData/RResp/RLast/RValid (master in), M_RReady (out)
//   AW channel : M_AWID/Addr/Len/Size/Burst/Valid (master out), M_AWReady (in)
//   W  channel : M_WData/WStrb/WLast/WValid (master out), M_WReady (in)
//   B  channel : M_BID/BResp/BValid (master in), M_BReady (out)
// -----------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

interface dma_master_engine_if;
  logic [`AXI_ID_BITS-1:0]   M_ARID;
  logic [`AXI_ADDR_BITS-1:0] M_ARAddr;
  logic [`AXI_LEN_BITS-1:0]  M_ARLen;
  logic [`AXI_SIZE_BITS-1:0] M_ARSize;
  logic [1:0]                M_ARBurst;
  logic                      M_ARValid;
  logic                      M_ARReady;

  logic [`AXI_ID_BITS-1:0]   M_RID;
  logic [`AXI_DATA_BITS-1:0] M_RData;
  logic [1:0]                M_RResp;
  logic                      M_RLast;
  logic                      M_RValid;
  logic                      M_RReady;

  logic [`AXI_ID_BITS-1:0]   M_AWID;
  logic [`AXI_ADDR_BITS-1:0] M_AWAddr;
  logic [`AXI_LEN_BITS-1:0]  M_AWLen;
  logic [`AXI_SIZE_BITS-1:0] M_AWSize;
  logic [1:0]                M_AWBurst;
  logic                      M_AWValid;
  logic                      M_AWReady;

  logic [`AXI_DATA_BITS-1:0] M_WData;
  logic [`AXI_STRB_BITS-1:0] M_WStrb;
  logic                      M_WLast;
  logic                      M_WValid;
  logic                      M_WReady;

  logic [`AXI_ID_BITS-1:0]   M_BID;
  logic [1:0]                M_BResp;
  logic                      M_BValid;
  logic                      M_BReady;

  modport master (
    output M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    input  M_ARReady,
    input  M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    output M_RReady,
    output M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid,
    input  M_AWReady,
    output M_WData, M_WStrb, M_WLast, M_WValid,
    input  M_WReady,
    input  M_BID, M_BResp, M_BValid,
    output M_BReady
  );

  modport slave (
    input  M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    output M_ARReady,
    output M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    input  M_RReady,
    input  M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid,
    output M_AWReady,
    input  M_WData, M_WStrb, M_WLast, M_WValid,
    output M_WReady,
    output M_BID, M_BResp, M_BValid,
    input  M_BReady
  );
endinterface

// File: rtl/dma_master_engine.sv
// -----------------------------------------------------------------------------
// dma_master_engine
// Word-copy DMA engine: moves DMALEN 32-bit words from DMASRC to DMADST as an
// AXI master, one INCR read burst into a local buffer followed by one INCR
// write burst out of it, repeated in chunks of at most MAX_BURST words.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   DMAEN           : start/enable level from the config slave
//   DMASRC, DMADST  : word-aligned source / destination byte addresses
//   DMALEN          : length in 32-bit words (0 completes immediately)
//   m               : AXI master port (dma_master_engine_if.master)
//   DMA_INTR        : completion level, high exactly while in DONE
//
// state | meaning
// IDLE  | waiting for DMAEN
// RADDR | read address presented, waiting for ARReady
// RDATA | accepting read beats into the buffer until RLast
// WADDR | write address presented, waiting for AWReady
// WDATA | streaming buffer out on W until WLast accepted
// WRESP | waiting for write response, then advance pointers
// DONE  | transfer complete, interrupt high until DMAEN drops
// -----------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module dma_master_engine #(
  parameter int MAX_BURST = 4,
  parameter int MST_ID    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DMAEN,
  input  logic [`AXI_DATA_BITS-1:0] DMASRC,
  input  logic [`AXI_DATA_BITS-1:0] DMADST,
  input  logic [`AXI_DATA_BITS-1:0] DMALEN,
  dma_master_engine_if.master       m,
  output logic                      DMA_INTR
);

  localparam int DW = `AXI_DATA_BITS;
  localparam int AW = `AXI_ADDR_BITS;
  localparam int LW = `AXI_LEN_BITS;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_DONE
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   src_q, dst_q;
  logic [DW-1:0]   remain_q;
  logic [CW-1:0]   chunk_q;
  logic [CW-1:0]   beat_q;
  logic [DW-1:0]   buf_q [MAX_BURST];
  logic            arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, intr_q;
  logic [AW-1:0]   araddr_q, awaddr_q;
  logic [LW-1:0]   arlen_q, awlen_q;

  function automatic logic [CW-1:0] clip_chunk(input logic [DW-1:0] n);
    if (n >= DW'(MAX_BURST)) return CW'(MAX_BURST);
    else                     return n[CW-1:0];
  endfunction

  logic [CW-1:0] start_chunk_d;
  logic [DW-1:0] remain_d;
  logic [CW-1:0] next_chunk_d;
  logic [AW-1:0] step_d;
  logic          wlast_d;

  assign start_chunk_d = clip_chunk(DMALEN);
  assign remain_d      = remain_q - DW'(chunk_q);
  assign next_chunk_d  = clip_chunk(remain_d);
  assign step_d        = AW'(chunk_q) << 2;
  assign wlast_d       = (beat_q == chunk_q - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      remain_q  <= '0;
      chunk_q   <= '0;
      beat_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      intr_q    <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      arlen_q   <= '0;
      awlen_q   <= '0;
      for (int i = 0; i < MAX_BURST; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DMAEN) begin
            if (DMALEN == '0) begin
              state_q <= S_DONE;
              intr_q  <= 1'b1;
            end else begin
              state_q   <= S_RADDR;
              src_q     <= DMASRC[AW-1:0];
              dst_q     <= DMADST[AW-1:0];
              remain_q  <= DMALEN;
              chunk_q   <= start_chunk_d;
              arvalid_q <= 1'b1;
              araddr_q  <= DMASRC[AW-1:0];
              arlen_q   <= LW'(start_chunk_d - CW'(1));
            end
          end
        end
        S_RADDR: begin
          if (m.M_ARReady) begin
            state_q   <= S_RDATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        S_RDATA: begin
          if (m.M_RValid) begin
            // extra beats past the buffer are dropped rather than wrapping
            if (beat_q < CW'(MAX_BURST)) begin
              buf_q[beat_q[IW-1:0]] <= m.M_RData;
              beat_q                <= beat_q + CW'(1);
            end
            // RLast terminates the burst regardless of the beat count
            if (m.M_RLast) begin
              state_q   <= S_WADDR;
              beat_q    <= '0;
              rready_q  <= 1'b0;
              awvalid_q <= 1'b1;
              awaddr_q  <= dst_q;
              awlen_q   <= LW'(chunk_q - CW'(1));
            end
          end
        end
        S_WADDR: begin
          if (m.M_AWReady) begin
            state_q   <= S_WDATA;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
          end
        end
        S_WDATA: begin
          if (m.M_WReady) begin
            if (wlast_d) begin
              state_q  <= S_WRESP;
              beat_q   <= '0;
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
            end else begin
              beat_q <= beat_q + CW'(1);
            end
          end
        end
        S_WRESP: begin
          if (m.M_BValid) begin
            bready_q <= 1'b0;
            src_q    <= src_q + step_d;
            dst_q    <= dst_q + step_d;
            remain_q <= remain_d;
            if (remain_d == '0) begin
              state_q <= S_DONE;
              intr_q  <= 1'b1;
            end else begin
              state_q   <= S_RADDR;
              chunk_q   <= next_chunk_d;
              arvalid_q <= 1'b1;
              araddr_q  <= src_q + step_d;
              arlen_q   <= LW'(next_chunk_d - CW'(1));
            end
          end
        end
        S_DONE: begin
          if (!DMAEN) begin
            state_q <= S_IDLE;
            intr_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m.M_ARID    = `AXI_ID_BITS'(MST_ID);
  assign m.M_ARAddr  = araddr_q;
  assign m.M_ARLen   = arlen_q;
  assign m.M_ARSize  = 3'b010;
  assign m.M_ARBurst = 2'b01;
  assign m.M_ARValid = arvalid_q;
  assign m.M_RReady  = rready_q;

  assign m.M_AWID    = `AXI_ID_BITS'(MST_ID);
  assign m.M_AWAddr  = awaddr_q;
  assign m.M_AWLen   = awlen_q;
  assign m.M_AWSize  = 3'b010;
  assign m.M_AWBurst = 2'b01;
  assign m.M_AWValid = awvalid_q;

  assign m.M_WData   = buf_q[beat_q[IW-1:0]];
  assign m.M_WStrb   = '1;
  assign m.M_WLast   = wvalid_q & wlast_d;
  assign m.M_WValid  = wvalid_q;
  assign m.M_BReady  = bready_q;

  assign DMA_INTR    = intr_q;

  // response IDs/codes are intentionally ignored
  logic unused_resp;
  assign unused_resp = ^{m.M_RID, m.M_RResp, m.M_BID, m.M_BResp};

endmodule

// File: tb/tb_dma_master_engine.sv
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module tb_dma_master_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        DMAEN;
  logic [31:0] DMASRC, DMADST, DMALEN;
  logic        DMA_INTR;

  dma_master_engine_if bus();

  dma_master_engine #(.MAX_BURST(4), .MST_ID(0)) dut (
    .clk(clk), .rst(rst), .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST),
    .DMALEN(DMALEN), .m(bus), .DMA_INTR(DMA_INTR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;
  ax_t exp_ar[$];
  ax_t exp_aw[$];
  w_t  exp_w[$];
  bit  exp_b[$];

  logic [31:0] mem_ovr [logic [31:0]];

  // slave behaviour knobs
  int ar_wait = 0, aw_wait = 0, b_wait = 0;
  bit r_gap = 0, w_toggle = 0, err_resp = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // ---------------- slave model ----------------
  ax_t rq[$];
  initial begin
    bit s_ar, s_r, s_aw, s_w, s_wlast, s_b, r_active, b_pend;
    logic [31:0] s_araddr, r_addr;
    logic [7:0]  s_arlen, r_len;
    int ar_cnt, aw_cnt, b_cnt, r_beat;
    r_active = 0; b_pend = 0; ar_cnt = 0; aw_cnt = 0; b_cnt = 0; r_beat = 0;
    r_addr = '0; r_len = '0;
    bus.M_ARReady = 0; bus.M_RValid = 0; bus.M_RData = '0; bus.M_RLast = 0;
    bus.M_RID = '0; bus.M_RResp = '0; bus.M_AWReady = 0; bus.M_WReady = 0;
    bus.M_BValid = 0; bus.M_BID = '0; bus.M_BResp = '0;
    forever begin
      @(negedge clk);
      s_ar = bus.M_ARValid & bus.M_ARReady;
      s_araddr = bus.M_ARAddr;
      s_arlen = 8'(bus.M_ARLen);
      s_r = bus.M_RValid & bus.M_RReady;
      s_aw = bus.M_AWValid & bus.M_AWReady;
      s_w = bus.M_WValid & bus.M_WReady;
      s_wlast = bus.M_WLast;
      s_b = bus.M_BValid & bus.M_BReady;
      @(posedge clk);
      #1;
      if (rst) begin
        rq.delete();
        r_active = 0; b_pend = 0; ar_cnt = 0; aw_cnt = 0; b_cnt = 0;
        bus.M_ARReady = 0; bus.M_RValid = 0; bus.M_RLast = 0;
        bus.M_AWReady = 0; bus.M_WReady = 0; bus.M_BValid = 0;
        continue;
      end
      bus.M_RResp = err_resp ? 2'b10 : 2'b00;
      bus.M_BResp = err_resp ? 2'b10 : 2'b00;
      if (s_ar) begin
        bus.M_ARReady = 0;
        rq.push_back('{addr: s_araddr, len: s_arlen});
        ar_cnt = 0;
      end else if (bus.M_ARValid && !bus.M_ARReady) begin
        if (ar_cnt >= ar_wait) bus.M_ARReady = 1;
        else ar_cnt++;
      end
      if (s_r) begin
        bus.M_RValid = 0;
        bus.M_RLast = 0;
        if (r_beat == int'(r_len)) r_active = 0;
        r_beat++;
      end
      if (!r_active && rq.size() > 0) begin
        ax_t t;
        t = rq.pop_front();
        r_addr = t.addr; r_len = t.len; r_beat = 0; r_active = 1;
      end
      if (r_active && !bus.M_RValid && !(r_gap && s_r)) begin
        bus.M_RValid = 1;
        bus.M_RData = mem_rd(r_addr + 32'(r_beat) * 4);
        bus.M_RLast = (r_beat == int'(r_len));
      end
      if (s_aw) begin
        bus.M_AWReady = 0;
        aw_cnt = 0;
      end else if (bus.M_AWValid && !bus.M_AWReady) begin
        if (aw_cnt >= aw_wait) bus.M_AWReady = 1;
        else aw_cnt++;
      end
      bus.M_WReady = w_toggle ? ~bus.M_WReady : 1'b1;
      if (s_b) bus.M_BValid = 0;
      if (s_w && s_wlast) begin b_pend = 1; b_cnt = 0; end
      if (b_pend) begin
        if (b_cnt >= b_wait) begin bus.M_BValid = 1; b_pend = 0; end
        else b_cnt++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit ar_pend, aw_pend, w_pend, intr_chk, intr_exp;
    logic [31:0] ar_hold, aw_hold, w_hold;
    ax_t ea;
    w_t  ew;
    ar_pend = 0; aw_pend = 0; w_pend = 0; intr_chk = 0; intr_exp = 0;
    ar_hold = '0; aw_hold = '0; w_hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_pend = 0; aw_pend = 0; w_pend = 0; intr_chk = 0;
        continue;
      end
      if (intr_chk) begin
        chk("intr_after_b", 32'(DMA_INTR), 32'(intr_exp));
        intr_chk = 0;
      end
      if (ar_pend) begin
        chk("ar_valid_held", 32'(bus.M_ARValid), 32'd1);
        chk("ar_addr_stable", bus.M_ARAddr, ar_hold);
      end
      if (aw_pend) begin
        chk("aw_valid_held", 32'(bus.M_AWValid), 32'd1);
        chk("aw_addr_stable", bus.M_AWAddr, aw_hold);
      end
      if (w_pend) begin
        chk("w_valid_held", 32'(bus.M_WValid), 32'd1);
        chk("w_data_stable", bus.M_WData, w_hold);
      end
      ar_pend = 0; aw_pend = 0; w_pend = 0;
      if (bus.M_ARValid) begin
        if (bus.M_ARReady) begin
          if (exp_ar.size() == 0) fail_evt("ar_unexpected");
          else begin
            ea = exp_ar.pop_front();
            chk("ar_addr", bus.M_ARAddr, ea.addr);
            chk("ar_len", 32'(bus.M_ARLen), 32'(ea.len));
            chk("ar_id", 32'(bus.M_ARID), 32'd0);
            chk("ar_size", 32'(bus.M_ARSize), 32'd2);
            chk("ar_burst", 32'(bus.M_ARBurst), 32'd1);
          end
        end else begin
          ar_pend = 1; ar_hold = bus.M_ARAddr;
        end
      end
      if (bus.M_AWValid) begin
        if (bus.M_AWReady) begin
          if (exp_aw.size() == 0) fail_evt("aw_unexpected");
          else begin
            ea = exp_aw.pop_front();
            chk("aw_addr", bus.M_AWAddr, ea.addr);
            chk("aw_len", 32'(bus.M_AWLen), 32'(ea.len));
            chk("aw_id", 32'(bus.M_AWID), 32'd0);
            chk("aw_burst", 32'(bus.M_AWBurst), 32'd1);
          end
        end else begin
          aw_pend = 1; aw_hold = bus.M_AWAddr;
        end
      end
      if (bus.M_WValid) begin
        if (bus.M_WReady) begin
          if (exp_w.size() == 0) fail_evt("w_unexpected");
          else begin
            ew = exp_w.pop_front();
            chk("w_data", bus.M_WData, ew.data);
            chk("w_last", 32'(bus.M_WLast), 32'(ew.last));
            chk("w_strb", 32'(bus.M_WStrb), 32'hF);
          end
        end else begin
          w_pend = 1; w_hold = bus.M_WData;
        end
      end
      if (bus.M_BValid && bus.M_BReady) begin
        if (exp_b.size() == 0) fail_evt("b_unexpected");
        else begin
          intr_exp = exp_b.pop_front();
          intr_chk = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_intr(input int budget);
    int n = 0;
    while (!DMA_INTR && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!DMA_INTR) begin
      checks++; failures++;
      $display("FAIL intr_timeout actual=0 required=1 after %0d cycles", budget);
    end
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] len, input bit drop_in_wdata);
    int off, rem, c, n;
    off = 0; rem = int'(len);
    while (rem > 0) begin
      c = (rem > 4) ? 4 : rem;
      exp_ar.push_back('{addr: src + 32'(off) * 4, len: 8'(c - 1)});
      exp_aw.push_back('{addr: dst + 32'(off) * 4, len: 8'(c - 1)});
      for (int i = 0; i < c; i++)
        exp_w.push_back('{data: mem_rd(src + 32'(off + i) * 4), last: (i == c - 1)});
      rem -= c;
      off += c;
      exp_b.push_back(rem == 0);
    end
    @(posedge clk); #1;
    DMASRC = src; DMADST = dst; DMALEN = len; DMAEN = 1;
    @(negedge clk);
    chk("intr_before_start", 32'(DMA_INTR), 32'd0);
    @(posedge clk); #1;
    DMASRC = 32'hBAD0_0000; DMADST = 32'hBAD1_0000; DMALEN = 32'd3;
    @(negedge clk);
    if (len == 0) begin
      chk("intr_zero_len", 32'(DMA_INTR), 32'd1);
      chk("zero_len_no_ar", 32'(bus.M_ARValid), 32'd0);
    end
    if (drop_in_wdata) begin
      n = 0;
      while (!bus.M_WValid && n < 200) begin @(negedge clk); n++; end
      chk("reached_wdata", 32'(bus.M_WValid), 32'd1);
      @(posedge clk); #1;
      DMAEN = 0;
      @(negedge clk);
      wait_intr(400);
      @(negedge clk);
      chk("intr_one_cycle_pulse", 32'(DMA_INTR), 32'd0);
    end else begin
      wait_intr(2000);
      repeat (2) @(negedge clk);
      chk("intr_held_in_done", 32'(DMA_INTR), 32'd1);
      @(posedge clk); #1;
      DMAEN = 0;
      @(posedge clk);
      @(negedge clk);
      chk("intr_clear_after_en_low", 32'(DMA_INTR), 32'd0);
    end
    repeat (2) @(negedge clk);
    chk("exp_ar_drained", 32'(exp_ar.size()), 32'd0);
    chk("exp_aw_drained", 32'(exp_aw.size()), 32'd0);
    chk("exp_w_drained", 32'(exp_w.size()), 32'd0);
    chk("exp_b_drained", 32'(exp_b.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1; DMAEN = 0; DMASRC = '0; DMADST = '0; DMALEN = '0;
    repeat (2) @(negedge clk);
    chk("rst_arvalid", 32'(bus.M_ARValid), 32'd0);
    chk("rst_awvalid", 32'(bus.M_AWValid), 32'd0);
    chk("rst_wvalid", 32'(bus.M_WValid), 32'd0);
    chk("rst_rready", 32'(bus.M_RReady), 32'd0);
    chk("rst_bready", 32'(bus.M_BReady), 32'd0);
    chk("rst_intr", 32'(DMA_INTR), 32'd0);
    chk("rst_araddr", bus.M_ARAddr, 32'd0);
    chk("rst_awaddr", bus.M_AWAddr, 32'd0);
    chk("rst_arlen", 32'(bus.M_ARLen), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // single word
    mem_ovr[32'h1000] = 32'hDEAD_BEEF;
    run_xfer(32'h1000, 32'h2000, 32'd1, 0);

    // split 4 + 2
    run_xfer(32'h4000, 32'h8000, 32'd6, 0);

    // backpressure on every channel, error responses ignored
    ar_wait = 3; aw_wait = 2; b_wait = 5; r_gap = 1; w_toggle = 1; err_resp = 1;
    run_xfer(32'h1100, 32'h9000, 32'd7, 0);
    ar_wait = 0; aw_wait = 0; b_wait = 0; r_gap = 0; w_toggle = 0; err_resp = 0;

    // zero length
    run_xfer(32'h7000, 32'h7100, 32'd0, 0);

    // DMAEN dropped during WDATA
    run_xfer(32'h2200, 32'h3300, 32'd4, 1);

    // reset during RDATA
    r_gap = 1;
    exp_ar.push_back('{addr: 32'h3000, len: 8'd3});
    @(posedge clk); #1;
    DMASRC = 32'h3000; DMADST = 32'h3800; DMALEN = 32'd8; DMAEN = 1;
    n = 0;
    @(negedge clk);
    while (!bus.M_RReady && n < 100) begin @(negedge clk); n++; end
    chk("reached_rdata", 32'(bus.M_RReady), 32'd1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_arvalid", 32'(bus.M_ARValid), 32'd0);
    chk("mid_rst_rready", 32'(bus.M_RReady), 32'd0);
    chk("mid_rst_awvalid", 32'(bus.M_AWValid), 32'd0);
    chk("mid_rst_wvalid", 32'(bus.M_WValid), 32'd0);
    chk("mid_rst_bready", 32'(bus.M_BReady), 32'd0);
    chk("mid_rst_intr", 32'(DMA_INTR), 32'd0);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_b.delete();
    DMAEN = 0; DMASRC = 32'h5000;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    r_gap = 0;
    run_xfer(32'h5000, 32'h6000, 32'd3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
